cell_draw_ctrl: RTL
===================

CELL_DRAW_CTRL -- requirements
Module: cell_draw_ctrl

Interface
REQ-001 The block SHALL have parameter CELL_W, default 8, meaning the cell width in pixels (2..16).
REQ-002 The block SHALL have parameter CELL_H, default 6, meaning the cell height in pixels (2..16).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to draw one cell; sampled only in IDLE.
REQ-006 Port X, input, 8 bits: cell origin x (top-left corner).
REQ-007 Port Y, input, 8 bits: cell origin y (top-left corner).
REQ-008 Port colour, input, 3 bits: cell colour.
REQ-009 Port draw_full, input, 1 bit: 1 draws a filled cell, 0 draws the outline only.
REQ-010 Port clear, input, 1 bit: 1 forces a filled draw in colour 3'b000.
REQ-011 Port vga_x, output, 8 bits: pixel x sent to the frame-buffer write port.
REQ-012 Port vga_y, output, 8 bits: pixel y sent to the frame-buffer write port.
REQ-013 Port vga_colour, output, 3 bits: pixel colour.
REQ-014 Port plot, output, 1 bit: pixel write enable.
REQ-015 Port busy, output, 1 bit: high while a cell is being drawn.
REQ-016 Port done, output, 1 bit: one-cycle pulse when a cell is complete.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-018 IDLE with start=1 at a clock edge SHALL latch X, Y, colour, draw_full and clear into internal registers, zero the counters dx and dy, and enter DRAW.
REQ-019 IDLE with start=0 SHALL remain in IDLE.
REQ-020 In DRAW, vga_x SHALL equal bx+dx and vga_y SHALL equal by+dy, computed modulo 256 so that results wrap past 255 to 0.
REQ-021 In DRAW, plot SHALL be 1 when the latched clear is 1 or the latched draw_full is 1, and otherwise only on border pixels (dx==0, dx==CELL_W-1, dy==0 or dy==CELL_H-1).
REQ-022 vga_colour SHALL be 3'b000 when the latched clear is 1, and the latched colour otherwise.
REQ-023 Each DRAW cycle SHALL increment dx; when dx==CELL_W-1, dx SHALL return to 0 and dy SHALL increment (raster order, row-major).
REQ-024 When dx==CELL_W-1 and dy==CELL_H-1, the next state SHALL be DONE, so DRAW lasts exactly CELL_W*CELL_H cycles.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 busy SHALL be 1 in DRAW and DONE and 0 in IDLE.
REQ-027 plot SHALL be 0 in IDLE and DONE.
REQ-028 start asserted in DRAW or DONE SHALL be ignored and not queued; changes to X, Y, colour, draw_full or clear during DRAW SHALL NOT affect the cell in progress.
REQ-029 start held high continuously SHALL start a new cell on each return to IDLE, with one IDLE cycle between cells.
REQ-030 vga_x, vga_y and vga_colour are don't-care when plot=0 but SHALL be driven from registers only, never directly from the inputs.

Reset
REQ-031 reset=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE, set dx=dy=0, set plot=busy=done=0, and clear the latched registers to 0.
REQ-032 Asserting reset in the middle of DRAW SHALL abort the cell with no further plot pulses; after release, the block SHALL wait in IDLE for a new start.

Verification
REQ-033 Full draw: X=28, Y=30, colour=100, draw_full=1, start pulse -> 48 plots covering x 28..35, y 30..35 in raster order, done in the 49th cycle after the start edge.
REQ-034 Outline draw: X=39, Y=38, colour=111, draw_full=0 -> 48 DRAW cycles, exactly 24 plots, all on the border pixels, colour 111.
REQ-035 Clear draw: clear=1, colour=111, draw_full=0 -> 48 plots, all with vga_colour=000.
REQ-036 Wrap: X=252, Y=254, draw_full=1 -> x sequence 252..255, 0..3 and y values 254, 255, 0..3.
REQ-037 Start pulsed and X changed at DRAW cycle 10 -> no restart and the original X is kept; exactly one done pulse.
REQ-038 reset=0 at DRAW cycle 20 -> plot and busy fall immediately; no done pulse; the next start draws a full 48-cycle cell.

Source files
------------

// File: rtl/cell_draw_ctrl.sv
// Cell rasteriser: walks a CELL_W x CELL_H rectangle in row-major order and
// emits one frame-buffer pixel write per cycle (filled, outline or clear).
module cell_draw_ctrl #(
    parameter int CELL_W = 8,
    parameter int CELL_H = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] X,
    input  logic [7:0] Y,
    input  logic [2:0] colour,
    input  logic       draw_full,
    input  logic       clear,
    output logic [7:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_X = 4'(CELL_W - 1);
    localparam logic [3:0] LAST_Y = 4'(CELL_H - 1);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_bx;
    logic [7:0] r_by;
    logic [2:0] r_colour;
    logic       r_full;
    logic       r_clear;
    logic [3:0] r_dx;
    logic [3:0] r_dy;
    logic       w_last_x;
    logic       w_last_y;
    logic       w_border;

    assign w_last_x = (r_dx == LAST_X);
    assign w_last_y = (r_dy == LAST_Y);
    assign w_border = (r_dx == 4'd0) || w_last_x || (r_dy == 4'd0) || w_last_y;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next is defaulted before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRAW;
            DRAW:    if (w_last_x && w_last_y) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bx     <= 8'd0;
            r_by     <= 8'd0;
            r_colour <= 3'd0;
            r_full   <= 1'b0;
            r_clear  <= 1'b0;
            r_dx     <= 4'd0;
            r_dy     <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bx     <= X;
                        r_by     <= Y;
                        r_colour <= colour;
                        r_full   <= draw_full;
                        r_clear  <= clear;
                        r_dx     <= 4'd0;
                        r_dy     <= 4'd0;
                    end
                end
                DRAW: begin
                    if (w_last_x) begin
                        r_dx <= 4'd0;
                        r_dy <= w_last_y ? 4'd0 : r_dy + 4'd1;
                    end else begin
                        r_dx <= r_dx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs derive only from registered state, so reset clears them at once
    // and input changes mid-cell cannot leak through; 8-bit sums wrap at 256.
    assign vga_x      = r_bx + {4'd0, r_dx};
    assign vga_y      = r_by + {4'd0, r_dy};
    assign vga_colour = r_clear ? 3'b000 : r_colour;
    assign plot       = (r_state == DRAW) && (r_clear || r_full || w_border);
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);

endmodule
